// File: rtl/vga_meas_pkg.sv
// Shared types for the VGA timing measurement block: counter width default,
// per-frame result record and lock FSM states.
package vga_meas_pkg;

  localparam int unsigned CwDefault = 12;
  // Result fields are held at a fixed width so the record is independent of CW.
  localparam int unsigned ResW = 32;

  typedef struct packed {
    logic [ResW-1:0] h_total;
    logic [ResW-1:0] h_active;
    logic [ResW-1:0] h_sync_w;
    logic [ResW-1:0] v_total;
    logic [ResW-1:0] v_active;
    logic [ResW-1:0] v_sync_w;
  } timing_t;

  typedef enum logic [1:0] {
    StUnlocked,
    StChecking,
    StLocked
  } lock_st_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Input register, polarity normalisation and leading-edge detection for a
// bundle of sync signals (one bit per sync line).
module vga_sync_edge #(
  parameter int unsigned N        = 2,
  parameter logic [N-1:0] ActLevel = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] sync_i,
  output logic [N-1:0] act_o,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= ~(sync_i ^ ActLevel);
      s2_q <= s1_q;
    end
  end

  assign act_o  = s1_q;
  assign rise_o = s1_q & ~s2_q;

endmodule

// File: rtl/vga_timing_meas.sv
// VGA sink timing measurement: per-frame H/V totals, active and sync widths and lock status.
// Defining VGA_TIMING_MEAS_CHECKSUM_EN adds the FRAME_SUM pixel checksum output.
module vga_timing_meas
  import vga_meas_pkg::*;
#(
  parameter int unsigned CW          = CwDefault,
  parameter logic        HS_ACT      = 1'b0,
  parameter logic        VS_ACT      = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    VGA_R,
  input  logic [7:0]    VGA_G,
  input  logic [7:0]    VGA_B,
  input  logic          VGA_HS,
  input  logic          VGA_VS,
  input  logic          VGA_DE,
  output logic [CW-1:0] H_TOTAL,
  output logic [CW-1:0] H_ACTIVE,
  output logic [CW-1:0] H_SYNC_W,
  output logic [CW-1:0] V_TOTAL,
  output logic [CW-1:0] V_ACTIVE,
  output logic [CW-1:0] V_SYNC_W,
  output logic          FRAME_DONE,
  output logic          LOCKED,
  output logic          SAT_ERR
`ifdef VGA_TIMING_MEAS_CHECKSUM_EN
  ,
  output logic [31:0]   FRAME_SUM
`endif
);

  localparam logic [CW-1:0] CntMax   = '1;
  localparam logic [3:0]    MatchMax = 4'hF;
  localparam logic [3:0]    LockThr  = 4'(LOCK_FRAMES - 1);

  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
    return (v == CntMax) ? v : v + CW'(1);
  endfunction

  // Stage 1 registers and sync edges
  logic [1:0] sync_act, sync_rise;
  logic       hs_act, vs_act, hs_rise, vs_rise;
  logic       de_q;

  vga_sync_edge #(
    .N       (2),
    .ActLevel({VS_ACT, HS_ACT})
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .sync_i({VGA_VS, VGA_HS}),
    .act_o (sync_act),
    .rise_o(sync_rise)
  );

  assign hs_act  = sync_act[0];
  assign vs_act  = sync_act[1];
  assign hs_rise = sync_rise[0];
  assign vs_rise = sync_rise[1];

  // Counter state
  logic [CW-1:0] h_cnt_q, h_cnt_d, hs_cnt_q, hs_cnt_d, de_cnt_q, de_cnt_d;
  logic [CW-1:0] h_tot_q, h_tot_n, h_sw_q, h_sw_n;
  logic [CW-1:0] h_act_q, h_act_n, h_act_d;
  logic [CW-1:0] v_tot_q, v_tot_n, v_tot_d;
  logic [CW-1:0] v_act_q, v_act_n, v_act_d;
  logic [CW-1:0] v_sync_q, v_sync_n, v_sync_d;
  logic          frame_sat_q, frame_sat_d, sat_now, close_sat;
  logic          frame_valid_q, res_valid_q, sat_err_q, done_q;
  logic          close;

  // Output result registers
  logic [CW-1:0] h_total_q, h_active_q, h_sync_w_q, v_total_q, v_active_q, v_sync_w_q;

  // Lock FSM
  lock_st_e   state_q, state_d;
  logic [3:0] match_q, match_d;
  logic       same;
  logic       sum_same;
  timing_t    cur_t, prev_t;

  assign close = vs_rise & frame_valid_q;

  // "_n" values fold in a line closing this cycle, so a coincident HS edge
  // is counted in the frame a VS edge closes.
  always_comb begin
    h_cnt_d  = hs_rise ? CW'(1) : inc_sat(h_cnt_q);
    hs_cnt_d = hs_rise ? CW'(1) : (hs_act ? inc_sat(hs_cnt_q) : hs_cnt_q);
    de_cnt_d = hs_rise ? CW'(de_q) : (de_q ? inc_sat(de_cnt_q) : de_cnt_q);

    h_tot_n  = hs_rise ? h_cnt_q : h_tot_q;
    h_sw_n   = hs_rise ? hs_cnt_q : h_sw_q;
    h_act_n  = (hs_rise && (de_cnt_q > h_act_q)) ? de_cnt_q : h_act_q;
    v_tot_n  = hs_rise ? inc_sat(v_tot_q) : v_tot_q;
    v_act_n  = (hs_rise && (de_cnt_q != '0)) ? inc_sat(v_act_q) : v_act_q;
    v_sync_n = (hs_rise && vs_act) ? inc_sat(v_sync_q) : v_sync_q;

    h_act_d  = vs_rise ? '0 : h_act_n;
    v_tot_d  = vs_rise ? '0 : v_tot_n;
    v_act_d  = vs_rise ? '0 : v_act_n;
    v_sync_d = vs_rise ? '0 : v_sync_n;

    sat_now = (h_cnt_d == CntMax) | (hs_cnt_d == CntMax) | (de_cnt_d == CntMax) |
              (v_tot_n == CntMax) | (v_act_n == CntMax) | (v_sync_n == CntMax);
    close_sat   = frame_sat_q | sat_now;
    frame_sat_d = vs_rise ? 1'b0 : close_sat;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      de_q          <= 1'b0;
      h_cnt_q       <= '0;
      hs_cnt_q      <= '0;
      de_cnt_q      <= '0;
      h_tot_q       <= '0;
      h_sw_q        <= '0;
      h_act_q       <= '0;
      v_tot_q       <= '0;
      v_act_q       <= '0;
      v_sync_q      <= '0;
      frame_sat_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      res_valid_q   <= 1'b0;
      sat_err_q     <= 1'b0;
      done_q        <= 1'b0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      h_sync_w_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      v_sync_w_q    <= '0;
    end else begin
      de_q          <= VGA_DE;
      h_cnt_q       <= h_cnt_d;
      hs_cnt_q      <= hs_cnt_d;
      de_cnt_q      <= de_cnt_d;
      h_tot_q       <= h_tot_n;
      h_sw_q        <= h_sw_n;
      h_act_q       <= h_act_d;
      v_tot_q       <= v_tot_d;
      v_act_q       <= v_act_d;
      v_sync_q      <= v_sync_d;
      frame_sat_q   <= frame_sat_d;
      frame_valid_q <= frame_valid_q | vs_rise;
      res_valid_q   <= res_valid_q | close;
      sat_err_q     <= sat_err_q | sat_now;
      done_q        <= close;
      if (close) begin
        h_total_q  <= h_tot_n;
        h_active_q <= h_act_n;
        h_sync_w_q <= h_sw_n;
        v_total_q  <= v_tot_n;
        v_active_q <= v_act_n;
        v_sync_w_q <= v_sync_n;
      end
    end
  end

`ifdef VGA_TIMING_MEAS_CHECKSUM_EN
  logic [23:0] rgb_q;
  logic [31:0] pix_add, sum_q, sum_d, frame_sum_q;

  // DE pixels of the VS-edge cycle belong to the frame being opened.
  always_comb begin
    pix_add = de_q ? {8'h00, rgb_q} : 32'h0;
    sum_d   = vs_rise ? pix_add : sum_q + pix_add;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rgb_q       <= '0;
      sum_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      rgb_q <= {VGA_R, VGA_G, VGA_B};
      sum_q <= sum_d;
      if (close) frame_sum_q <= sum_q;
    end
  end

  assign sum_same  = (sum_q == frame_sum_q);
  assign FRAME_SUM = frame_sum_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{VGA_R, VGA_G, VGA_B};
  assign sum_same   = 1'b1;
`endif

  always_comb begin
    cur_t           = '0;
    cur_t.h_total   = ResW'(h_tot_n);
    cur_t.h_active  = ResW'(h_act_n);
    cur_t.h_sync_w  = ResW'(h_sw_n);
    cur_t.v_total   = ResW'(v_tot_n);
    cur_t.v_active  = ResW'(v_act_n);
    cur_t.v_sync_w  = ResW'(v_sync_n);
    prev_t          = '0;
    prev_t.h_total  = ResW'(h_total_q);
    prev_t.h_active = ResW'(h_active_q);
    prev_t.h_sync_w = ResW'(h_sync_w_q);
    prev_t.v_total  = ResW'(v_total_q);
    prev_t.v_active = ResW'(v_active_q);
    prev_t.v_sync_w = ResW'(v_sync_w_q);
    same            = (cur_t == prev_t) && sum_same;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StUnlocked;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  // The first frame after reset has nothing to compare against and is not a mismatch.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    if (close) begin
      if (close_sat || (res_valid_q && !same)) begin
        state_d = StUnlocked;
        match_d = '0;
      end else begin
        if (res_valid_q && (match_q != MatchMax)) match_d = match_q + 4'd1;
        state_d = (match_d >= LockThr) ? StLocked : StChecking;
      end
    end
  end

  always_comb begin
    LOCKED = (state_q == StLocked);
  end

  assign H_TOTAL    = h_total_q;
  assign H_ACTIVE   = h_active_q;
  assign H_SYNC_W   = h_sync_w_q;
  assign V_TOTAL    = v_total_q;
  assign V_ACTIVE   = v_active_q;
  assign V_SYNC_W   = v_sync_w_q;
  assign FRAME_DONE = done_q;
  assign SAT_ERR    = sat_err_q;

endmodule

// File: tb/tb_vga_timing_meas.sv
// Scoreboard bench for vga_timing_meas: random frame geometries, expected results from geometry.
`timescale 1ns/1ps
module tb_vga_timing_meas;

  localparam int unsigned CW     = 12;
  localparam int unsigned LF     = 2;
  localparam logic        HS_ACT = 1'b0;
  localparam logic        VS_ACT = 1'b0;
`ifdef VGA_TIMING_MEAS_CHECKSUM_EN
  localparam bit SumEn = 1'b1;
`else
  localparam bit SumEn = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic          VGA_HS = ~HS_ACT;
  logic          VGA_VS = ~VS_ACT;
  logic          VGA_DE = 1'b0;
  logic [CW-1:0] H_TOTAL, H_ACTIVE, H_SYNC_W, V_TOTAL, V_ACTIVE, V_SYNC_W;
  logic          FRAME_DONE, LOCKED, SAT_ERR;
`ifdef VGA_TIMING_MEAS_CHECKSUM_EN
  logic [31:0]   FRAME_SUM;
`endif

  vga_timing_meas #(
    .CW(CW), .HS_ACT(HS_ACT), .VS_ACT(VS_ACT), .LOCK_FRAMES(LF)
  ) dut (
    .CLK(CLK), .RST(RST),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .H_SYNC_W(H_SYNC_W),
    .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .V_SYNC_W(V_SYNC_W),
    .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED), .SAT_ERR(SAT_ERR)
`ifdef VGA_TIMING_MEAS_CHECKSUM_EN
    , .FRAME_SUM(FRAME_SUM)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int htot, hact, hoff, hsw, vtot, vact, voff, vsw;
    bit long_last;
  } geom_t;

  typedef struct {
    int          h_total, h_active, h_sync_w, v_total, v_active, v_sync_w;
    bit          locked;
    logic [31:0] sum;
    longint      done_cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   pend, m_prev, mon_e;
  bit     pend_v = 0, m_prev_v = 0;
  int     m_match = 0;
  int     n_cmp = 0, n_bad = 0, fd_cnt = 0;
  longint cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input bit hs, input bit vs, input bit de, input logic [23:0] rgb);
    VGA_HS = hs ? HS_ACT : ~HS_ACT;
    VGA_VS = vs ? VS_ACT : ~VS_ACT;
    VGA_DE = de;
    {VGA_R, VGA_G, VGA_B} = rgb;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // Called in the cycle a VS leading edge is driven: it closes the pending frame.
  task automatic open_frame();
    bit same;
    if (pend_v) begin
      pend.done_cyc = cyc + 2;
      same = m_prev_v && pend.h_total == m_prev.h_total && pend.h_active == m_prev.h_active &&
             pend.h_sync_w == m_prev.h_sync_w && pend.v_total == m_prev.v_total &&
             pend.v_active == m_prev.v_active && pend.v_sync_w == m_prev.v_sync_w &&
             (!SumEn || pend.sum == m_prev.sum);
      if (!m_prev_v) m_match = 0;
      else if (same) m_match = (m_match < 15) ? m_match + 1 : 15;
      else m_match = 0;
      pend.locked = (m_prev_v && !same) ? 1'b0 : (m_match >= int'(LF) - 1);
      m_prev   = pend;
      m_prev_v = 1'b1;
      exp_q.push_back(pend);
    end
    pend_v = 1'b0;
  endtask

  // Frame: HS at line start, VS on the first vsw lines; stop_after > 0 aborts mid-frame.
  task automatic gen_frame(input geom_t g, input int stop_after);
    exp_t        e;
    int          n = 0;
    int          hl;
    logic [23:0] pix;
    logic [31:0] s = '0;
    bit          de;
    open_frame();
    for (int l = 0; l < g.vtot; l++) begin
      hl = (g.long_last && l == g.vtot - 1) ? g.htot + 1 : g.htot;
      for (int x = 0; x < hl; x++) begin
        if (stop_after > 0 && n == stop_after) return;
        de  = (l >= g.voff) && (l < g.voff + g.vact) && (x >= g.hoff) && (x < g.hoff + g.hact);
        pix = 24'($urandom());
        if (de) s = s + {8'h00, pix};
        drive(x < g.hsw, l < g.vsw, de, de ? pix : 24'h0);
        n++;
      end
    end
    e.h_total  = g.long_last ? g.htot + 1 : g.htot;
    e.h_active = g.hact;
    e.h_sync_w = g.hsw;
    e.v_total  = g.vtot;
    e.v_active = g.vact;
    e.v_sync_w = g.vsw;
    e.locked   = 1'b0;
    e.sum      = s;
    e.done_cyc = 0;
    pend       = e;
    pend_v     = 1'b1;
  endtask

  task automatic close_stream();
    open_frame();
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    idle(20);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    RST = 1'b0;
    pend_v   = 1'b0;
    m_prev_v = 1'b0;
    m_match  = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_h_total"}, H_TOTAL, 0);
    check({tag, "_h_active"}, H_ACTIVE, 0);
    check({tag, "_h_sync_w"}, H_SYNC_W, 0);
    check({tag, "_v_total"}, V_TOTAL, 0);
    check({tag, "_v_active"}, V_ACTIVE, 0);
    check({tag, "_v_sync_w"}, V_SYNC_W, 0);
    check({tag, "_frame_done"}, FRAME_DONE, 0);
    check({tag, "_locked"}, LOCKED, 0);
    check({tag, "_sat_err"}, SAT_ERR, 0);
  endtask

  always @(negedge CLK) begin
    if (!RST && FRAME_DONE === 1'b1) begin
      fd_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame_done: got a pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("h_total", H_TOTAL, mon_e.h_total);
        check("h_active", H_ACTIVE, mon_e.h_active);
        check("h_sync_w", H_SYNC_W, mon_e.h_sync_w);
        check("v_total", V_TOTAL, mon_e.v_total);
        check("v_active", V_ACTIVE, mon_e.v_active);
        check("v_sync_w", V_SYNC_W, mon_e.v_sync_w);
        check("locked", LOCKED, mon_e.locked);
        check("sat_err", SAT_ERR, 0);
        check("done_cycle", cyc, mon_e.done_cyc);
`ifdef VGA_TIMING_MEAS_CHECKSUM_EN
        check("frame_sum", FRAME_SUM, mon_e.sum);
`endif
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    geom_t ga, gl, gr;
    int    fd_before;
    ga = '{htot: 50, hact: 40, hoff: 6, hsw: 4, vtot: 30, vact: 24, voff: 3, vsw: 2,
           long_last: 1'b0};
    gl = ga;
    gl.long_last = 1'b1;

    do_reset();
    check_zero("reset");

    // Dead input: counters saturate with no sync edges
    fd_before = fd_cnt;
    idle(5000);
    check("dead_sat_err", SAT_ERR, 1);
    check("dead_locked", LOCKED, 0);
    check("dead_frame_done_count", fd_cnt, fd_before);

    do_reset();
    check_zero("reset2");

    // Stable stream, one lengthened last line, then recovery
    for (int i = 0; i < 3; i++) gen_frame(ga, 0);
    gen_frame(gl, 0);
    for (int i = 0; i < 3; i++) gen_frame(ga, 0);

    // Random geometries, two frames each
    for (int k = 0; k < 4; k++) begin
      gr.htot = $urandom_range(64, 24);
      gr.hsw  = $urandom_range(8, 1);
      gr.hact = $urandom_range(gr.htot - 8, 4);
      gr.hoff = $urandom_range(gr.htot - gr.hact, 0);
      gr.vtot = $urandom_range(30, 10);
      gr.vsw  = $urandom_range(3, 1);
      gr.vact = $urandom_range(gr.vtot - 4, 1);
      gr.voff = $urandom_range(gr.vtot - gr.vact, 0);
      gr.long_last = 1'b0;
      gen_frame(gr, 0);
      gen_frame(gr, 0);
    end

    // Mid-frame reset discards the partial frame
    gen_frame(ga, 300);
    check("queue_drained_before_reset", exp_q.size(), 0);
    do_reset();
    check_zero("midreset");
    idle(10);
    for (int i = 0; i < 3; i++) gen_frame(ga, 0);
    close_stream();

    check("queue_empty_at_end", exp_q.size(), 0);
    check("sat_err_end", SAT_ERR, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
